// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared fetch-stage types.
//   pc_sel_t          : next-PC source chosen by fetch_pc_unit
//   RAS_DEPTH_DEFAULT : default return address stack depth
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_REDIR,
    PC_RAS,
    PC_FLUSH,
    PC_HOLD
  } pc_sel_t;

  localparam int RAS_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/return_address_stack.sv
// -----------------------------------------------------------------------------
// return_address_stack
// Circular return address stack with a top pointer and a saturating count.
// Pushing onto a full stack overwrites the oldest entry. push and pop are
// expected to be pre-qualified by the caller (stall/flush already removed).
//   clk, rst : clock, asynchronous active-high reset (pointer/count only)
//   push     : write wdata as the new top
//   pop      : discard the top (ignored when empty)
//   wdata    : address to push
//   top      : current top entry (don't-care when empty)
//   empty    : no valid entries
//   full     : RAS_DEPTH valid entries
//   count    : number of valid entries
// -----------------------------------------------------------------------------
module return_address_stack
  import cpu_types_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT,
  parameter int PC_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [PC_W-1:0]            wdata,
  output logic [PC_W-1:0]            top,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(RAS_DEPTH):0] count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_tp_next;
  logic [PTR_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_count_next;
  logic             w_we;
  logic             w_nonempty;

  assign w_nonempty = (r_count != '0);

  always_comb begin
    w_tp_next    = r_tp;
    w_count_next = r_count;
    w_wr_idx     = r_tp;
    w_we         = 1'b0;
    if (push && pop && w_nonempty) begin
      // Pop-then-push collapses to overwriting the top slot in place.
      w_we = 1'b1;
    end else if (push) begin
      // Circular pointer: on a full stack this lands on the oldest entry.
      w_tp_next = r_tp + PTR_ONE;
      w_wr_idx  = r_tp + PTR_ONE;
      w_we      = 1'b1;
      if (r_count != CNT_MAX) w_count_next = r_count + CNT_ONE;
    end else if (pop && w_nonempty) begin
      w_tp_next    = r_tp - PTR_ONE;
      w_count_next = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tp    <= '0;
      r_count <= '0;
    end else begin
      r_tp    <= w_tp_next;
      r_count <= w_count_next;
    end
  end

  // Entry storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_idx] <= wdata;
  end

  assign top   = r_mem[r_tp];
  assign empty = !w_nonempty;
  assign full  = (r_count == CNT_MAX);
  assign count = r_count;

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Fetch-stage program counter: registered PC/PC4, priority next-PC select
// (flush > stall > RAS return > redirect > sequential) and optional return
// address stack.
// Build option: define FETCH_PC_RAS_EN to instantiate the return address
// stack. Without it, call_push/ret_pop are ignored and the RAS status outputs
// read constant empty.
//   CLK, RST        : clock, asynchronous active-high reset
//   stall           : hold PC and RAS
//   flush_valid/_target       : execute-stage correction (beats stall)
//   redirect_valid/_target    : decode-stage jump
//   call_push, call_ret_addr  : push a return address
//   ret_pop         : predict a return from the RAS top
//   PC, PC4         : current fetch address and PC + INSTR_BYTES
//   ras_empty, ras_full, ras_count : RAS occupancy
// -----------------------------------------------------------------------------
module fetch_pc_unit
  import cpu_types_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] PC_INIT     = '0,
  parameter int              INSTR_BYTES = 4,
  parameter int              RAS_DEPTH   = RAS_DEPTH_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       stall,
  input  logic                       flush_valid,
  input  logic [PC_W-1:0]            flush_target,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_target,
  input  logic                       call_push,
  input  logic [PC_W-1:0]            call_ret_addr,
  input  logic                       ret_pop,
  output logic [PC_W-1:0]            PC,
  output logic [PC_W-1:0]            PC4,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  localparam logic [PC_W-1:0] INC        = PC_W'(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(INSTR_BYTES - 1);

  function automatic logic [PC_W-1:0] f_align(input logic [PC_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  localparam logic [PC_W-1:0] RESET_PC = f_align(PC_INIT);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc4;

  pc_sel_t         w_sel;
  logic [PC_W-1:0] w_pc_next;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_hit;

`ifdef FETCH_PC_RAS_EN
  logic w_push;
  logic w_pop;

  // The stack only moves on cycles where fetch actually advances.
  assign w_push = call_push & ~stall & ~flush_valid;
  assign w_pop  = ret_pop   & ~stall & ~flush_valid;

  return_address_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (call_ret_addr),
    .top   (w_ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .count (ras_count)
  );

  // A return on an empty stack gives no prediction and falls through.
  assign w_ras_hit = ret_pop & ~ras_empty;
`else
  logic w_unused_ras;

  assign w_unused_ras = ^{call_push, ret_pop, call_ret_addr};
  assign w_ras_top    = '0;
  assign w_ras_hit    = 1'b0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_count    = '0;
`endif

  always_comb begin
    w_sel = PC_SEQ;
    if (flush_valid)         w_sel = PC_FLUSH;
    else if (stall)          w_sel = PC_HOLD;
    else if (w_ras_hit)      w_sel = PC_RAS;
    else if (redirect_valid) w_sel = PC_REDIR;
  end

  always_comb begin
    w_pc_next = r_pc4;
    case (w_sel)
      PC_FLUSH: w_pc_next = f_align(flush_target);
      PC_HOLD:  w_pc_next = r_pc;
      PC_RAS:   w_pc_next = f_align(w_ras_top);
      PC_REDIR: w_pc_next = f_align(redirect_target);
      default:  w_pc_next = r_pc4;
    endcase
  end

  // PC4 is registered alongside PC; the add wraps modulo 2^PC_W.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc  <= RESET_PC;
      r_pc4 <= RESET_PC + INC;
    end else begin
      r_pc  <= w_pc_next;
      r_pc4 <= w_pc_next + INC;
    end
  end

  assign PC  = r_pc;
  assign PC4 = r_pc4;

endmodule
